// File: rtl/counter4_down.sv
// 4-bit synchronous down-counter with parallel load, auto-reload from a
// load register, and a registered borrow/terminal pulse for cascading.
module counter4_down (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [1:0] modo,
  input  logic [3:0] data,
  output logic [3:0] Q,
  output logic       rco,
  output logic       zero
);

  localparam int unsigned W = 4;

  typedef enum logic [1:0] {
    MODE_DOWN1  = 2'b00,
    MODE_DOWN3  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_RELOAD = 2'b11
  } mode_t;

  logic [W-1:0] rld;
  mode_t        mode;

  assign mode = mode_t'(modo);

  // Count, load and borrow; borrow decisions always use the pre-edge count.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q   <= '0;
      rco <= 1'b0;
      rld <= W'(4'hF);
    end else if (!enb) begin
      rco <= 1'b0;
    end else begin
      case (mode)
        MODE_DOWN1: begin
          Q   <= Q - W'(1);
          rco <= (Q == '0);
        end
        MODE_DOWN3: begin
          Q   <= Q - W'(3);
          rco <= (Q < W'(3));
        end
        MODE_LOAD: begin
          Q   <= data;
          rld <= data;
          rco <= 1'b0;
        end
        MODE_RELOAD: begin
          if (Q != '0) begin
            Q   <= Q - W'(1);
            rco <= 1'b0;
          end else begin
            Q   <= rld;
            rco <= 1'b1;
          end
        end
      endcase
    end
  end

  assign zero = (Q == '0);

endmodule

// File: tb/tb_counter4_down.sv
// Bench for counter4_down: directed scenarios with fixed expectations plus
// a randomized run, every cycle compared against an arithmetic reference model.
module tb_counter4_down;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [1:0] modo;
  logic [3:0] data;
  logic [3:0] Q;
  logic       rco;
  logic       zero;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_q   = 0;
  int m_rld = 15;
  int m_rco = 0;

  counter4_down dut (
    .clk  (clk),
    .rst  (rst),
    .enb  (enb),
    .modo (modo),
    .data (data),
    .Q    (Q),
    .rco  (rco),
    .zero (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Spec rules applied with plain integer arithmetic.
  task automatic model_edge(input int r, input int e, input int m, input int d);
    if (r != 0) begin
      m_q = 0; m_rco = 0; m_rld = 15;
    end else if (e == 0) begin
      m_rco = 0;
    end else if (m == 0) begin
      m_rco = (m_q == 0) ? 1 : 0;
      m_q   = (m_q + 16 - 1) % 16;
    end else if (m == 1) begin
      m_rco = (m_q < 3) ? 1 : 0;
      m_q   = (m_q + 16 - 3) % 16;
    end else if (m == 2) begin
      m_q = d; m_rld = d; m_rco = 0;
    end else if (m_q != 0) begin
      m_q = m_q - 1; m_rco = 0;
    end else begin
      m_q = m_rld; m_rco = 1;
    end
  endtask

  // Drive one cycle, update the model at the edge, compare just after it.
  task automatic step(input int r, input int e, input int m, input int d);
    rst  = r[0];
    enb  = e[0];
    modo = 2'(m);
    data = 4'(d);
    @(posedge clk);
    model_edge(r, e, m, d);
    #1;
    check("model_q", int'(Q), m_q);
    check("model_rco", int'(rco), m_rco);
    check("model_zero", int'(zero), (m_q == 0) ? 1 : 0);
  endtask

  initial begin
    int ar_q [8];
    int r, e;
    ar_q = '{2, 1, 0, 3, 2, 1, 0, 3};

    rst = 1'b1; enb = 1'b0; modo = 2'b00; data = 4'h0;
    #2;

    // reset then full down-by-1 wrap
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_q", int'(Q), 0);
    check("rst_rco", int'(rco), 0);
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 0, 0);
      check("wrap_q", int'(Q), (15 - i + 16) % 16);
      check("wrap_rco", int'(rco), (i == 0 || i == 16) ? 1 : 0);
    end

    // down by 3 with borrow
    step(0, 1, 2, 4);
    step(0, 1, 1, 0); check("dn3_q0", int'(Q), 1);  check("dn3_r0", int'(rco), 0);
    step(0, 1, 1, 0); check("dn3_q1", int'(Q), 14); check("dn3_r1", int'(rco), 1);
    step(0, 1, 1, 0); check("dn3_q2", int'(Q), 11); check("dn3_r2", int'(rco), 0);

    // auto-reload from 3
    step(0, 1, 2, 3);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3, 0);
      check("ar_q", int'(Q), ar_q[i]);
      check("ar_rco", int'(rco), (i == 3 || i == 7) ? 1 : 0);
      check("ar_zero", int'(zero), (ar_q[i] == 0) ? 1 : 0);
    end

    // reload value 0 keeps pulsing
    step(0, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 3, 0);
      check("rld0_q", int'(Q), 0);
      check("rld0_rco", int'(rco), 1);
    end

    // enable hold at 9
    step(0, 1, 2, 10);
    step(0, 1, 0, 0);
    check("hold_start", int'(Q), 9);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      check("hold_q", int'(Q), 9);
      check("hold_rco", int'(rco), 0);
    end
    step(0, 1, 0, 0);
    check("hold_resume", int'(Q), 8);

    // reset mid-operation restores rld to F
    step(0, 1, 2, 6);
    step(0, 1, 3, 0);
    step(0, 1, 3, 0);
    check("mid_pre_q", int'(Q), 4);
    step(1, 1, 3, 0);
    check("mid_rst_q", int'(Q), 0);
    check("mid_rst_rco", int'(rco), 0);
    step(0, 1, 3, 0);
    check("mid_rld_q", int'(Q), 15);
    check("mid_rld_rco", int'(rco), 1);
    step(0, 1, 3, 0);
    check("mid_next_q", int'(Q), 14);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(31) == 0) ? 1 : 0;
      e = ($urandom_range(3) != 0) ? 1 : 0;
      step(r, e, int'($urandom_range(3)), int'($urandom_range(15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
